// File: rtl/soi_pkg.sv
// rtl/soi_pkg.sv - shared widths and record word layout for the SOI change logger
package soi_pkg;
   localparam int DROP_CNT_WIDTH = 16;
   localparam int DEF_WIDTH      = 8;
   localparam int DEF_DEPTH      = 16;
   localparam int DEF_TS_WIDTH   = 32;
   localparam int DEF_REC_WIDTH  = DEF_WIDTH + DEF_TS_WIDTH + 1;

   // Record word layout is {value, tstamp, lost}, MSB first.
   typedef struct packed {
      logic [DEF_WIDTH-1:0]    value;
      logic [DEF_TS_WIDTH-1:0] tstamp;
      logic                    lost;
   } soi_rec_t;

   function automatic logic [DEF_REC_WIDTH-1:0] rec_pack(input soi_rec_t rec);
      return rec;
   endfunction

   function automatic soi_rec_t rec_unpack(input logic [DEF_REC_WIDTH-1:0] word);
      return soi_rec_t'(word);
   endfunction
endpackage

// File: rtl/soi_fifo.sv
// rtl/soi_fifo.sv - show-ahead synchronous FIFO accepting a push into a full queue when a pop coincides
module soi_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          wr_accept,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic [DW-1:0] mem [DEPTH];
   logic          rd_en;

   assign empty     = (wptr == rptr);
   assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rd_en     = pop && !empty;
   assign wr_accept = push && (!full || rd_en);
   // Head is forced to zero when empty so outputs read as zero straight out of reset.
   assign rdata     = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wptr[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_accept) wptr <= wptr + 1'b1;
         if (rd_en)     rptr <= rptr + 1'b1;
      end
   end
endmodule

// File: rtl/soi_change_logger.sv
// rtl/soi_change_logger.sv - timestamps changes of a watched bus and queues records for a reader
module soi_change_logger
   import soi_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int TS_WIDTH = DEF_TS_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [WIDTH-1:0]          soi,
   output logic                      rec_valid,
   input  logic                      rec_ready,
   output logic [WIDTH-1:0]          rec_value,
   output logic [TS_WIDTH-1:0]       rec_time,
   output logic                      rec_lost,
   output logic [DROP_CNT_WIDTH-1:0] drop_count
);
   localparam int REC_W = WIDTH + TS_WIDTH + 1;

   logic [TS_WIDTH-1:0] ts;
   logic [WIDTH-1:0]    prev;
   logic                first;
   logic                pending_lost;
   logic                event_hit;
   logic                accepted;
   logic                full;
   logic                empty;
   logic [REC_W-1:0]    wr_word;
   logic [REC_W-1:0]    rd_word;

   assign event_hit = enable && (first || (soi != prev));
   assign wr_word   = {soi, ts, pending_lost};
   assign rec_valid = !empty;
   assign {rec_value, rec_time, rec_lost} = rd_word;

   soi_fifo #(
      .DW    (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (event_hit),
      .wdata     (wr_word),
      .pop       (rec_ready),
      .rdata     (rd_word),
      .wr_accept (accepted),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts           <= '0;
         prev         <= '0;
         first        <= 1'b1;
         pending_lost <= 1'b0;
         drop_count   <= '0;
      end else begin
         ts <= ts + 1'b1;
         if (enable) begin
            prev  <= soi;
            first <= 1'b0;
         end
         if (event_hit) begin
            if (accepted) begin
               pending_lost <= 1'b0;
            end else begin
               pending_lost <= 1'b1;
               if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
         end
      end
   end

   logic unused_full;
   assign unused_full = full;
endmodule

// File: tb/tb_soi_change_logger.sv
// tb/tb_soi_change_logger.sv - directed self-checking bench for soi_change_logger
module tb_soi_change_logger;
   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [7:0]  soi;
   logic        rec_valid;
   logic        rec_ready;
   logic [7:0]  rec_value;
   logic [31:0] rec_time;
   logic        rec_lost;
   logic [15:0] drop_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   soi_change_logger dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .soi        (soi),
      .rec_valid  (rec_valid),
      .rec_ready  (rec_ready),
      .rec_value  (rec_value),
      .rec_time   (rec_time),
      .rec_lost   (rec_lost),
      .drop_count (drop_count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One rising edge; returns at the following falling edge where outputs are sampled.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int cnt;
      logic [7:0] last;

      rst = 1'b1; enable = 1'b1; soi = 8'h00; rec_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_val("reset_valid", 32'(rec_valid), 0);
      check_val("reset_drop", 32'(drop_count), 0);
      check_val("reset_value", 32'(rec_value), 0);
      check_val("reset_time", rec_time, 0);
      check_val("reset_lost", 32'(rec_lost), 0);

      // First enabled edge after reset always logs, at ts 0.
      rst = 1'b0;
      step();
      check_val("first_valid", 32'(rec_valid), 1);
      check_val("first_value", 32'(rec_value), 32'h00);
      check_val("first_time", rec_time, 0);
      check_val("first_lost", 32'(rec_lost), 0);
      step();
      check_val("const_none1", 32'(rec_valid), 0);
      step(); step();
      check_val("const_none2", 32'(rec_valid), 0);

      // 0x00 -> 0x05 -> 0x05 -> 0xA0 on edges 4..6
      soi = 8'h05; step();
      check_val("step05_value", 32'(rec_value), 32'h05);
      check_val("step05_time", rec_time, 4);
      step();
      check_val("repeat05_none", 32'(rec_valid), 0);
      soi = 8'hA0; step();
      check_val("stepA0_value", 32'(rec_value), 32'hA0);
      check_val("stepA0_time", rec_time, 6);
      step();
      check_val("stepA0_popped", 32'(rec_valid), 0);

      // Overflow: 20 changes into a 16-deep FIFO with the reader stalled.
      rec_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         soi = 8'h40 + 8'(i);
         step();
      end
      check_val("ovf_drop", 32'(drop_count), 4);
      check_val("ovf_head", 32'(rec_value), 32'h40);
      rec_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         check_val("drain_value", 32'(rec_value), 32'h40 + k);
         check_val("drain_lost", 32'(rec_lost), 0);
         step();
      end
      check_val("drain_empty", 32'(rec_valid), 0);
      soi = 8'h77; step();
      check_val("after_drop_value", 32'(rec_value), 32'h77);
      check_val("after_drop_lost", 32'(rec_lost), 1);
      soi = 8'h78; step();
      check_val("next_value", 32'(rec_value), 32'h78);
      check_val("next_lost", 32'(rec_lost), 0);
      step();
      check_val("next_popped", 32'(rec_valid), 0);

      // Full FIFO with a push and pop on the same edge: nothing dropped.
      rec_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         soi = 8'h80 + 8'(i);
         step();
      end
      check_val("refill_drop", 32'(drop_count), 4);
      rec_ready = 1'b1; soi = 8'h99; step();
      check_val("fullpp_drop", 32'(drop_count), 4);
      cnt = 0; last = 8'h00;
      while (rec_valid && cnt < 40) begin
         last = rec_value;
         cnt++;
         step();
      end
      check_val("fullpp_count", cnt, 16);
      check_val("fullpp_last", 32'(last), 32'h99);

      // Enable gating: prev holds while disabled.
      soi = 8'h11; step(); step();
      enable = 1'b0; soi = 8'h22; step(); step();
      check_val("disabled_none", 32'(rec_valid), 0);
      enable = 1'b1; step();
      check_val("reenable_valid", 32'(rec_valid), 1);
      check_val("reenable_value", 32'(rec_value), 32'h22);
      step();
      enable = 1'b0; soi = 8'h33; step(); soi = 8'h22; step();
      enable = 1'b1; step();
      check_val("reenable_same_none", 32'(rec_valid), 0);

      // Async reset with records queued.
      rec_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         soi = 8'(i);
         step();
      end
      check_val("prerst_valid", 32'(rec_valid), 1);
      rst = 1'b1;
      #1;
      check_val("async_valid", 32'(rec_valid), 0);
      check_val("async_drop", 32'(drop_count), 0);
      check_val("async_value", 32'(rec_value), 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check_val("post_rst_value", 32'(rec_value), 32'h05);
      check_val("post_rst_time", rec_time, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
